// File: rtl/bme280_meas_seq.sv
// BME280 bring-up and periodic measurement sequencer driving bme280_i2c_ctrl.
// Power-up wait, chip-ID check, config write chain, then periodic 8-byte bursts from 0xF7.
module bme280_meas_seq #(
  parameter int                DWIDTH     = 8,
  parameter int                INIT_CYC   = 100_000,
  parameter int                PERIOD_CYC = 5_000_000,
  parameter logic [DWIDTH-1:0] CTRL_HUM   = 8'h01,
  parameter logic [DWIDTH-1:0] CONFIG     = 8'h00,
  parameter logic [DWIDTH-1:0] CTRL_MEAS  = 8'h27,
  parameter logic [DWIDTH-1:0] CHIP_ID    = 8'h60
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Meas_en,
  output logic              I2C_start,
  output logic              I2C_rdwr,
  output logic              I2C_last,
  output logic [DWIDTH-1:0] I2C_addr,
  output logic [DWIDTH-1:0] I2C_txd,
  input  logic [DWIDTH-1:0] I2C_rxd,
  input  logic              I2C_done,
  output logic [19:0]       Press_raw,
  output logic [19:0]       Temp_raw,
  output logic [15:0]       Hum_raw,
  output logic              Data_valid,
  output logic              Busy,
  output logic              Id_ok,
  output logic              Id_err
);

  localparam int IW = $clog2(INIT_CYC);
  localparam int PW = $clog2(PERIOD_CYC + 1);

  typedef enum logic [2:0] {S_INIT, S_RD_ID, S_CFG, S_WAIT, S_BURST, S_HALT} state_t;

  state_t            state;
  logic [IW-1:0]     icnt;
  logic [PW-1:0]     pcnt;
  logic [2:0]        idx;
  logic              pend;
  logic [DWIDTH-1:0] shadow [0:6];

  logic              issue, done_ok;
  logic              nxt_rd, nxt_last;
  logic [DWIDTH-1:0] nxt_addr, nxt_txd;

  // Fields of the byte about to be issued. INIT and WAIT launch the first byte of
  // the following transaction on their exit edge, so they select its fields too.
  always_comb begin
    nxt_rd   = 1'b0;
    nxt_last = 1'b0;
    nxt_addr = '0;
    nxt_txd  = '0;
    case (state)
      S_INIT, S_RD_ID: begin
        nxt_rd   = 1'b1;
        nxt_addr = 8'hD0;
        nxt_last = 1'b1;
      end
      S_CFG: begin
        case (idx)
          3'd0:    begin nxt_addr = 8'hF2; nxt_txd = CTRL_HUM; end
          3'd1:    begin nxt_addr = 8'hF5; nxt_txd = CONFIG;   end
          default: begin nxt_addr = 8'hF4; nxt_txd = CTRL_MEAS; nxt_last = 1'b1; end
        endcase
      end
      S_WAIT, S_BURST: begin
        nxt_rd   = 1'b1;
        nxt_addr = 8'hF7;
        nxt_last = (state == S_BURST) && (idx == 3'd7);
      end
      default: ;
    endcase
  end

  always_comb begin
    done_ok = I2C_done && pend;
    issue   = ((state == S_INIT) && (icnt == '0)) ||
              ((state == S_WAIT) && Meas_en && (pcnt == '0)) ||
              (((state == S_CFG) || (state == S_BURST)) && !pend);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state      <= S_INIT;
      icnt       <= IW'(INIT_CYC - 1);
      pcnt       <= '0;
      idx        <= '0;
      pend       <= 1'b0;
      I2C_start  <= 1'b0;
      I2C_rdwr   <= 1'b0;
      I2C_last   <= 1'b0;
      I2C_addr   <= '0;
      I2C_txd    <= '0;
      Press_raw  <= '0;
      Temp_raw   <= '0;
      Hum_raw    <= '0;
      Data_valid <= 1'b0;
      Busy       <= 1'b0;
      Id_ok      <= 1'b0;
      Id_err     <= 1'b0;
      for (int unsigned i = 0; i < 7; i++) shadow[i] <= '0;
    end else begin
      I2C_start  <= 1'b0;
      Data_valid <= 1'b0;
      if ((state == S_WAIT || state == S_BURST || state == S_HALT) && pcnt != '0)
        pcnt <= pcnt - 1'b1;
      if (issue) begin
        I2C_start <= 1'b1;
        pend      <= 1'b1;
        Busy      <= 1'b1;
        I2C_rdwr  <= nxt_rd;
        I2C_last  <= nxt_last;
        I2C_addr  <= nxt_addr;
        I2C_txd   <= nxt_txd;
      end
      case (state)
        S_INIT: begin
          if (icnt == '0) state <= S_RD_ID;
          else            icnt  <= icnt - 1'b1;
        end
        S_RD_ID: begin
          if (done_ok) begin
            pend <= 1'b0;
            Busy <= 1'b0;
            if (I2C_rxd == CHIP_ID) begin
              Id_ok <= 1'b1;
              state <= S_CFG;
            end else begin
              Id_err <= 1'b1;
              state  <= S_HALT;
            end
          end
        end
        S_CFG: begin
          if (done_ok) begin
            pend <= 1'b0;
            if (idx == 3'd2) begin
              Busy  <= 1'b0;
              idx   <= '0;
              state <= S_WAIT;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (Meas_en && pcnt == '0) begin
            pcnt  <= PW'(PERIOD_CYC - 1);
            state <= S_BURST;
          end
        end
        S_BURST: begin
          if (done_ok) begin
            pend <= 1'b0;
            if (idx == 3'd7) begin
              // Final byte goes straight to the outputs so all three words update together.
              Press_raw  <= {shadow[0], shadow[1], shadow[2][7:4]};
              Temp_raw   <= {shadow[3], shadow[4], shadow[5][7:4]};
              Hum_raw    <= {shadow[6], I2C_rxd};
              Data_valid <= 1'b1;
              Busy       <= 1'b0;
              idx        <= '0;
              state      <= S_WAIT;
            end else begin
              shadow[idx] <= I2C_rxd;
              idx         <= idx + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
